// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN board front-end.
package knn_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam int CLASS   = 0;
  localparam int KMODE   = 1;
  localparam int LAT_LSB = 2;

  localparam int LAT_MAX = 63;
  localparam int COORD_W = 8;
  localparam int CNT_W   = 8;

  // Button slots in the packed command vector
  localparam int NUM_BTN    = 4;
  localparam int BTN_LOAD_X = 0;
  localparam int BTN_LOAD_Y = 1;
  localparam int BTN_START  = 2;
  localparam int BTN_TOGGLE = 3;
endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: one-cycle pulse per low-to-high button transition.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= btn;
  end

  assign pulse = btn & ~prev;
endmodule

// File: rtl/knn_session_ctrl.sv
// Session sequencer: button commands, query/K registers, one engine run per
// start, result and latency latching, LED status word.
module knn_session_ctrl
  import knn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LAT_W          = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] switches,
  input  logic               btn_load_x,
  input  logic               btn_load_y,
  input  logic               btn_start,
  input  logic               btn_toggle_k,
  output logic [COORD_W-1:0] query_x,
  output logic [COORD_W-1:0] query_y,
  output logic               k_sel,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic               eng_class,
  output logic               busy,
  output logic               err,
  output logic [7:0]         leds
);
  localparam logic [CNT_W:0] TMO     = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] LAT_SAT = (CNT_W+1)'(LAT_MAX);

  logic [NUM_BTN-1:0] btn_lvl, cmd;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;
  logic               idle, timeout;
  logic               class_q;
  logic [LAT_W-1:0]   lat_q;

  assign btn_lvl = {btn_toggle_k, btn_start, btn_load_y, btn_load_x};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge u_edge (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lvl[i]),
      .pulse (cmd[i])
    );
  end

  // cnt_inc is the latency if done lands this cycle; one bit wider so it never wraps
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign timeout = (cnt_inc == TMO);
  assign idle    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd[BTN_START]) state_nxt = ARM;
      ARM:     state_nxt = RUN;
      RUN:     if (eng_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      query_x <= '0;
      query_y <= '0;
      k_sel   <= 1'b0;
      cnt     <= '0;
      class_q <= 1'b0;
      lat_q   <= '0;
      err     <= 1'b0;
    end else begin
      // Loads and toggle share the start edge, so the engine sees them in ARM
      if (idle) begin
        if (cmd[BTN_LOAD_X]) query_x <= switches;
        if (cmd[BTN_LOAD_Y]) query_y <= switches;
        if (cmd[BTN_TOGGLE]) k_sel   <= ~k_sel;
      end
      case (state)
        ARM: cnt <= '0;
        RUN: begin
          cnt <= cnt_inc[CNT_W-1:0];
          if (eng_done) begin
            class_q <= eng_class;
            lat_q   <= (cnt_inc > LAT_SAT) ? LAT_W'(LAT_MAX) : cnt_inc[LAT_W-1:0];
            err     <= 1'b0;
          end else if (timeout) begin
            lat_q <= LAT_W'(LAT_MAX);
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_start = (state == ARM);
  assign busy      = ~idle;

  always_comb begin
    leds                      = '0;
    leds[CLASS]               = class_q;
    leds[KMODE]               = k_sel;
    leds[LAT_LSB +: LAT_W]    = lat_q;
  end
endmodule

// File: tb/tb_knn_session_ctrl.sv
// Directed bench for knn_session_ctrl with a programmable-latency engine model.
module tb_knn_session_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switches;
  logic       btn_load_x, btn_load_y, btn_start, btn_toggle_k;
  logic [7:0] query_x, query_y;
  logic       k_sel, eng_start, eng_done, eng_class, busy, err;
  logic [7:0] leds;

  int checks = 0;
  int errors = 0;

  // Engine model: done arrives mdl_n cycles after the eng_start cycle; 0 = never
  int         mdl_n = 0;
  logic       mdl_class = 1'b0;
  int         rem = 0;
  int         starts = 0;
  logic [7:0] cap_x, cap_y;
  logic       cap_k;

  always #5 clk = ~clk;

  knn_session_ctrl dut (
    .clk(clk), .reset(reset), .switches(switches),
    .btn_load_x(btn_load_x), .btn_load_y(btn_load_y),
    .btn_start(btn_start), .btn_toggle_k(btn_toggle_k),
    .query_x(query_x), .query_y(query_y), .k_sel(k_sel),
    .eng_start(eng_start), .eng_done(eng_done), .eng_class(eng_class),
    .busy(busy), .err(err), .leds(leds)
  );

  always @(posedge clk) begin
    if (eng_start && mdl_n != 0) rem <= mdl_n;
    else if (rem != 0)           rem <= rem - 1;
    if (eng_start) begin
      starts <= starts + 1;
      cap_x  <= query_x;
      cap_y  <= query_y;
      cap_k  <= k_sel;
    end
  end
  assign eng_done  = (rem == 1);
  assign eng_class = mdl_class;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask: {toggle, start, load_y, load_x}; returns in the cycle after the sampling edge
  task automatic press(input logic [3:0] mask);
    {btn_toggle_k, btn_start, btn_load_y, btn_load_x} = mask;
    @(negedge clk);
    {btn_toggle_k, btn_start, btn_load_y, btn_load_x} = 4'b0000;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) @(negedge clk);
    if (busy) check({tag, "_wait_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; switches = 8'h00;
    {btn_toggle_k, btn_start, btn_load_y, btn_load_x} = 4'b0000;
    tick(2);
    check("rst_leds", 32'(leds), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_qx",   32'(query_x), 32'h00);
    check("rst_ksel", 32'(k_sel), 32'd0);
    reset = 1'b0;
    tick(1);

    // Load and run
    switches = 8'h10;
    press(4'b0001);
    check("load_x", 32'(query_x), 32'h10);
    press(4'b0010);
    check("load_y", 32'(query_y), 32'h10);
    mdl_n = 5; mdl_class = 1'b1; base = starts;
    press(4'b0100);
    check("arm_start", 32'(eng_start), 32'd1);
    check("arm_busy",  32'(busy), 32'd1);
    wait_idle("run1", 50);
    check("run1_starts", 32'(starts - base), 32'd1);
    check("run1_capx",   32'(cap_x), 32'h10);
    check("run1_capy",   32'(cap_y), 32'h10);
    check("run1_leds",   32'(leds), 32'b000101_0_1);

    // Saturation and K toggle
    press(4'b1000);
    check("toggle_k",    32'(k_sel), 32'd1);
    check("toggle_led",  32'(leds[1]), 32'd1);
    mdl_n = 68; mdl_class = 1'b0;
    press(4'b0100);
    tick(30);
    check("sat_busy",    32'(busy), 32'd1);
    check("sat_ksel",    32'(k_sel), 32'd1);
    wait_idle("sat", 100);
    check("sat_capk",    32'(cap_k), 32'd1);
    check("sat_leds",    32'(leds), 32'b111111_1_0);

    // Busy lockout
    mdl_n = 40; mdl_class = 1'b1; base = starts;
    press(4'b0100);
    tick(5);
    switches = 8'hEC;
    press(4'b1101);
    tick(2);
    check("lock_qx",     32'(query_x), 32'h10);
    check("lock_ksel",   32'(k_sel), 32'd1);
    wait_idle("lock", 80);
    check("lock_starts", 32'(starts - base), 32'd1);
    check("lock_leds",   32'(leds), 32'b101000_1_1);

    // Timeout: ARM plus 255 RUN cycles busy
    mdl_n = 0;
    press(4'b0100);
    n = 0;
    while (busy && n < 400) begin n++; @(negedge clk); end
    check("tmo_busy_cycles", 32'(n), 32'd256);
    check("tmo_err",     32'(err), 32'd1);
    check("tmo_leds",    32'(leds), 32'b111111_1_1);
    mdl_n = 3; mdl_class = 1'b0;
    press(4'b0100);
    wait_idle("after_tmo", 20);
    check("clr_err",     32'(err), 32'd0);
    check("clr_leds",    32'(leds), 32'b000011_1_0);

    // Held start gives one run
    mdl_n = 4; base = starts;
    btn_start = 1'b1;
    tick(20);
    btn_start = 1'b0;
    tick(3);
    check("held_starts", 32'(starts - base), 32'd1);
    check("held_busy",   32'(busy), 32'd0);

    // Simultaneous loads with start
    switches = 8'hF4;
    press(4'b0111);
    wait_idle("simul", 20);
    check("simul_capx",  32'(cap_x), 32'hF4);
    check("simul_capy",  32'(cap_y), 32'hF4);

    // Reset mid-RUN
    mdl_n = 30; mdl_class = 1'b1;
    press(4'b0100);
    tick(10);
    check("mid_busy",    32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mr_leds",     32'(leds), 32'h00);
    check("mr_busy",     32'(busy), 32'd0);
    check("mr_start",    32'(eng_start), 32'd0);
    check("mr_err",      32'(err), 32'd0);
    check("mr_ksel",     32'(k_sel), 32'd0);
    check("mr_q",        32'({query_x, query_y}), 32'h0000);
    tick(25);
    check("late_busy",   32'(busy), 32'd0);
    check("late_leds",   32'(leds), 32'h00);
    mdl_n = 2; mdl_class = 1'b1; base = starts;
    press(4'b0100);
    wait_idle("fresh", 20);
    check("fresh_starts", 32'(starts - base), 32'd1);
    check("fresh_leds",  32'(leds), 32'b000010_0_1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/knn_session_ctrl.md
# knn_session_ctrl

Front-end sequencer for the KNN inference engine on the board build. It turns raw button presses into single-cycle commands, holds the query coordinates and the K-mode setting, and starts one engine run per accepted start press. It then latches the predicted class and the measured latency, and drives the 8-bit LED status word. It sits between the board I/O in `top` and the engine instance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of RUN cycles before the run is abandoned.
- `LAT_W`, default 6: latency field width; fixed by the LED map.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `switches` in 8: Q4.4 signed coordinate source.
- `btn_load_x`, `btn_load_y`, `btn_start`, `btn_toggle_k` in 1 each: level-sampled buttons, synchronous to `clk`.
- `query_x`, `query_y` out 8: coordinate registers to the engine.
- `k_sel` out 1: 0 = K3, 1 = K5; held stable while busy.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_done` in 1: one-cycle completion pulse from the engine.
- `eng_class` in 1: engine vote result, valid when `eng_done` is high.
- `busy` out 1: high in ARM and RUN.
- `err` out 1: sticky timeout flag.
- `leds` out 8: [0] latched class, [1] live `k_sel`, [7:2] latched latency.

## Operation
- Edge detect: command = button high this cycle AND low at the previous posedge. A held button gives exactly one command.
- States and transitions:
  - IDLE → ARM on a start command.
  - ARM lasts one cycle: `eng_start`=1; latency counter cleared to 0. Then → RUN.
  - RUN: counter increments by 1 every cycle.
  - RUN → IDLE on `eng_done`: latch `eng_class`; latch min(counter+1, 63); clear `err`.
  - RUN → IDLE when the counter reaches `TIMEOUT_CYCLES` with no done: `err`=1; latency field = 63; class unchanged.
- Latency = cycles from the `eng_start` cycle to the `eng_done` cycle, saturating at 63. The counter itself is 8 bits wide for the timeout.
- Command handling in IDLE:
  - `load_x` captures `switches` into `query_x`; `load_y` captures into `query_y`.
  - `toggle_k` inverts `k_sel`.
  - Commands arriving in the same cycle all apply.
  - A load/toggle in the same cycle as start is applied before ARM, so the engine sees the new values.
- While busy: load, toggle and start commands are discarded, not queued.
- `eng_done` outside RUN is ignored. `eng_done` during ARM is ignored.
- Reset at any point, including mid-RUN:
  - next state IDLE;
  - `eng_start`, `busy`, `err`, `k_sel`, `query_x`, `query_y`, `leds` all 0.
  - The engine's own reset is handled separately.

## Timing
- Start press sampled at edge E: ARM is at E+1 with `eng_start` high, RUN from E+2.
- Load press at edge E: `query_*` updated after E, visible in cycle E+1.
- Toggle press at edge E: `leds[1]` changes after E.
- Result with `eng_done` at edge D: `leds[0]`, `leds[7:2]` and `busy`=0 are visible after D.
- A new start is accepted at edge D+1 at the earliest.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `knn_pkg`:
  - state enum: IDLE, ARM, RUN;
  - LED bit-index constants: CLASS=0, KMODE=1, LAT_LSB=2;
  - `LAT_MAX` = 63;
  - coordinate width 8.
- One sub-module, `btn_edge`: registered previous level, `pulse` output. Instantiated four times.
- The FSM, counter and result registers live in `knn_session_ctrl`.

## Test plan
All scenarios use a bench engine model that raises `eng_done` a programmable N cycles after `eng_start`, with `eng_class` programmable.

- Load and run: load X=0x10, load Y=0x10, start; model N=5, class=1. Expect:
  - `query_x`/`query_y`=0x10 at the start pulse;
  - exactly one `eng_start`;
  - `leds`=8'b000101_0_1.
- Saturation and K toggle: toggle_k, then start with N=68, class=0. Expect:
  - `k_sel`=1 throughout RUN;
  - `leds`[7:2]=63, `leds`[1]=1, `leds`[0]=0.
- Busy lockout: during RUN, press load_x with switches=0xEC, and also press start and toggle_k. Expect:
  - `query_x` unchanged;
  - no second `eng_start`;
  - `k_sel` unchanged.
- Timeout: model never asserts done. Expect:
  - return to IDLE after 255 RUN cycles;
  - `err`=1, latency field 63;
  - next successful run (N=3) clears `err` and shows latency 3.
- Held button and simultaneous commands:
  - start held high for 20 cycles gives exactly one run;
  - load_x, load_y and start in the same cycle with switches=0xF4 gives the engine X=Y=0xF4 at `eng_start`.
- Reset mid-RUN: assert reset for 1 cycle at RUN cycle 10. Expect:
  - all outputs 0 on the next cycle;
  - a late `eng_done` is ignored;
  - a fresh start works normally afterwards.
